// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_if
// Purpose  : Bundles the sequencer's three bus attachments: instruction
//            fetch, register-file read/write and the combinational ALU.
// Ports    : master - sequencer side (drives requests, addresses, operands)
//            slave  - memory / register file / ALU side
// Revision : 1.0  initial release
// ============================================================================
interface alu_seq_ctrl_if;
   // instruction fetch
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   // register file
   logic [3:0]  rf_raddr_a;
   logic [3:0]  rf_raddr_b;
   logic [15:0] rf_rdata_a;
   logic [15:0] rf_rdata_b;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   // ALU
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [7:0]  alu_op;
   logic        alu_cin;
   logic [4:0]  alu_flags;
   logic [15:0] alu_result;

   modport master (
      output imem_req, imem_addr, rf_raddr_a, rf_raddr_b,
             rf_we, rf_waddr, rf_wdata, alu_a, alu_b, alu_op, alu_cin,
      input  imem_ack, imem_data, rf_rdata_a, rf_rdata_b,
             alu_flags, alu_result
   );

   modport slave (
      input  imem_req, imem_addr, rf_raddr_a, rf_raddr_b,
             rf_we, rf_waddr, rf_wdata, alu_a, alu_b, alu_op, alu_cin,
      output imem_ack, imem_data, rf_rdata_a, rf_rdata_b,
             alu_flags, alu_result
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Multi-cycle sequencer (FETCH/DECODE/EXECUTE/WRITEBACK) driving a
//            combinational ALU. Decodes 16-bit instructions, captures flags
//            into the PSR, writes results back and resolves branches.
// Ports    : clk, rst_n (async active-low)
//            bus    - fetch, register-file and ALU signals (master modport)
//            psr    - captured flags {N,Z,F,L,C}
//            pc     - program counter
//            halted - high once HALT (IR == 0) has been decoded
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_ctrl_if.master bus,
   output logic [4:0]    psr,
   output logic [15:0]   pc,
   output logic          halted
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   logic [2:0]  r_state;
   logic [15:0] r_ir;
   logic        r_run;     // keeps imem_req low until the first edge after reset
   logic [15:0] r_src;     // source operand (register or extended immediate)
   logic [15:0] r_dst;     // destination register value
   logic [15:0] r_res;     // write-back value latched at end of EXECUTE
   logic [15:0] r_pc;
   logic [4:0]  r_psr;

   logic [3:0]  w_opc, w_ext, w_fn;
   logic [15:0] w_immx, w_disp;
   logic        w_rform, w_use_imm, w_alu, w_inv, w_swap, w_wr, w_mov;
   logic        w_upd_c, w_upd_cmp, w_br, w_taken, w_req, w_exec_alu;
   logic [7:0]  w_op;

   assign w_opc  = r_ir[15:12];
   assign w_ext  = r_ir[7:4];
   assign w_disp = {{8{r_ir[7]}}, r_ir[7:0]};

   // Immediate forms reuse the register-form function table, keyed by opcode.
   always_comb begin
      w_fn      = 4'h0;
      w_rform   = 1'b0;
      w_use_imm = 1'b0;
      w_immx    = {{8{r_ir[7]}}, r_ir[7:0]};
      w_alu     = 1'b0;
      w_op      = 8'h00;
      w_inv     = 1'b0;
      w_swap    = 1'b0;
      w_wr      = 1'b0;
      w_mov     = 1'b0;
      w_upd_c   = 1'b0;
      w_upd_cmp = 1'b0;
      w_br      = 1'b0;
      case (w_opc)
         4'h0: begin
            w_fn    = w_ext;
            w_rform = 1'b1;
         end
         4'h1, 4'h2, 4'h3: begin
            w_fn      = w_opc;
            w_rform   = 1'b1;
            w_use_imm = 1'b1;
            w_immx    = {8'h00, r_ir[7:0]};
         end
         4'h5, 4'h9, 4'hB, 4'hD: begin
            w_fn      = w_opc;
            w_rform   = 1'b1;
            w_use_imm = 1'b1;
         end
         4'h8: begin
            if (w_ext == 4'h4 || w_ext == 4'h6) begin
               w_alu  = 1'b1;
               w_op   = {w_opc, w_ext};
               w_swap = 1'b1;
               w_wr   = 1'b1;
            end
         end
         4'hC:    w_br = 1'b1;
         default: ;
      endcase
      if (w_rform) begin
         case (w_fn)
            4'h1, 4'h2, 4'h3: begin
               w_alu = 1'b1;
               w_op  = {4'h0, w_fn};
               w_wr  = 1'b1;
            end
            4'h5: begin
               w_alu   = 1'b1;
               w_op    = 8'h05;
               w_wr    = 1'b1;
               w_upd_c = 1'b1;
            end
            4'h9: begin
               // subtract as Rdest + ~src + 1
               w_alu   = 1'b1;
               w_op    = 8'h05;
               w_inv   = 1'b1;
               w_wr    = 1'b1;
               w_upd_c = 1'b1;
            end
            4'hB: begin
               w_alu     = 1'b1;
               w_op      = 8'h0B;
               w_upd_cmp = 1'b1;
            end
            4'hD: begin
               w_mov = 1'b1;
               w_wr  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Branch condition against the PSR {N,Z,F,L,C}.
   always_comb begin
      w_taken = 1'b0;
      case (r_ir[11:8])
         4'h0: w_taken =  r_psr[3];
         4'h1: w_taken = !r_psr[3];
         4'h2: w_taken =  r_psr[0];
         4'h3: w_taken = !r_psr[0];
         4'h4: w_taken =  r_psr[1];
         4'h5: w_taken = !r_psr[1];
         4'h6: w_taken =  r_psr[4];
         4'h7: w_taken = !r_psr[4];
         4'h8: w_taken =  r_psr[2];
         4'h9: w_taken = !r_psr[2];
         4'hA: w_taken = !r_psr[1] && !r_psr[3];
         4'hB: w_taken =  r_psr[1] ||  r_psr[3];
         4'hC: w_taken = !r_psr[4] && !r_psr[3];
         4'hD: w_taken =  r_psr[4] ||  r_psr[3];
         4'hE: w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_req      = (r_state == S_FETCH) && r_run;
   assign w_exec_alu = (r_state == S_EXEC) && w_alu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_ir    <= 16'h0000;
         r_run   <= 1'b0;
         r_src   <= 16'h0000;
         r_dst   <= 16'h0000;
         r_res   <= 16'h0000;
         r_pc    <= RESET_PC;
         r_psr   <= 5'b00000;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            S_FETCH: begin
               if (w_req && bus.imem_ack) begin
                  r_ir    <= bus.imem_data;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_ir == 16'h0000) begin
                  r_state <= S_HALT;
               end else begin
                  r_src   <= w_use_imm ? w_immx : bus.rf_rdata_a;
                  r_dst   <= bus.rf_rdata_b;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_res <= w_mov ? r_src : bus.alu_result;
               // only flags that are meaningful for the op are captured
               if (w_upd_c)   r_psr[0]   <= bus.alu_flags[0];
               if (w_upd_cmp) r_psr[4:1] <= bus.alu_flags[4:1];
               r_state <= S_WB;
            end
            S_WB: begin
               r_pc    <= (w_br && w_taken) ? (r_pc + w_disp) : (r_pc + 16'd1);
               r_state <= S_FETCH;
            end
            S_HALT:  ;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = r_pc;
   assign bus.rf_raddr_a = r_ir[3:0];
   assign bus.rf_raddr_b = r_ir[11:8];
   assign bus.rf_we      = (r_state == S_WB) && w_wr;
   assign bus.rf_waddr   = r_ir[11:8];
   assign bus.rf_wdata   = r_res;
   // shifts take the value from Rdest and the amount from Rsrc
   assign bus.alu_a   = w_exec_alu ? (w_swap ? r_dst : (w_inv ? ~r_src : r_src)) : 16'h0000;
   assign bus.alu_b   = w_exec_alu ? (w_swap ? r_src : r_dst) : 16'h0000;
   assign bus.alu_op  = w_exec_alu ? w_op : 8'h00;
   assign bus.alu_cin = w_exec_alu && w_inv;

   assign psr    = r_psr;
   assign pc     = r_pc;
   assign halted = (r_state == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Directed self-checking bench for alu_seq_ctrl with a behavioural
//            register file, instruction feed and combinational ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;
   logic        clk;
   logic        rst_n;
   logic [4:0]  psr;
   logic [15:0] pc;
   logic        halted;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl #(.RESET_PC(16'h0000)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .psr    (psr),
      .pc     (pc),
      .halted (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] rf [16];
   assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
   assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

   // ALU model; unused flag positions carry junk so leaks into psr show up.
   logic [16:0] m_sum;
   int          m_amt;
   always_comb begin
      m_sum          = 17'(bus.alu_a) + 17'(bus.alu_b) + 17'(bus.alu_cin);
      m_amt          = int'($signed(bus.alu_b));
      bus.alu_result = 16'h0000;
      bus.alu_flags  = 5'b00000;
      case (bus.alu_op)
         8'h01: bus.alu_result = bus.alu_a & bus.alu_b;
         8'h02: bus.alu_result = bus.alu_a | bus.alu_b;
         8'h03: bus.alu_result = bus.alu_a ^ bus.alu_b;
         8'h05: begin
            bus.alu_result = m_sum[15:0];
            bus.alu_flags  = {4'b1111, m_sum[16]};
         end
         8'h0B: bus.alu_flags = {($signed(bus.alu_b) > $signed(bus.alu_a)),
                                 (bus.alu_a == bus.alu_b), 1'b0,
                                 (bus.alu_b > bus.alu_a), 1'b0};
         8'h84: bus.alu_result = (m_amt >= 0) ? (bus.alu_a << m_amt) : (bus.alu_a >> (-m_amt));
         8'h86: bus.alu_result = (m_amt >= 0) ? (bus.alu_a << m_amt)
                                              : 16'($signed(bus.alu_a) >>> (-m_amt));
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // values observed during the last instruction
   logic [7:0]  e_op;
   logic [15:0] e_a, e_b;
   logic        e_cin;
   logic        w_we;
   logic [3:0]  w_addr;
   logic [15:0] w_data;

   task automatic wait_req();
      int n = 0;
      while (!bus.imem_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_seen", 32'(bus.imem_req), 32'd1);
   endtask

   // Fetch one instruction with dly wait cycles and step through it.
   task automatic run_instr(input logic [15:0] ir, input int dly);
      wait_req();
      for (int i = 0; i < dly; i++) begin
         @(posedge clk); #1;
         check("req_held", 32'(bus.imem_req), 32'd1);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = ir;
      @(posedge clk); #1;               // DECODE
      bus.imem_ack  = 1'b0;
      @(posedge clk); #1;               // EXECUTE
      e_op  = bus.alu_op;
      e_a   = bus.alu_a;
      e_b   = bus.alu_b;
      e_cin = bus.alu_cin;
      @(posedge clk); #1;               // WRITEBACK
      w_we   = bus.rf_we;
      w_addr = bus.rf_waddr;
      w_data = bus.rf_wdata;
      if (w_we) rf[w_addr] = w_data;
      @(posedge clk); #1;               // next FETCH
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
      bus.imem_ack  = 1'b0;
      bus.imem_data = 16'h0000;
      rst_n = 1'b0;
      #12;
      check("rst_pc",     32'(pc), 32'h0);
      check("rst_psr",    32'(psr), 32'h0);
      check("rst_req",    32'(bus.imem_req), 32'h0);
      check("rst_we",     32'(bus.rf_we), 32'h0);
      check("rst_aluop",  32'(bus.alu_op), 32'h0);
      check("rst_alua",   32'(bus.alu_a), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      #10 rst_n = 1'b1;                 // t=22
      #1;
      check("req_before_edge", 32'(bus.imem_req), 32'h0);
      @(posedge clk); #1;
      check("req_first_edge", 32'(bus.imem_req), 32'h1);
      check("fetch_addr",     32'(bus.imem_addr), 32'h0);

      // ADD R1,R2
      rf[1] = 16'd3; rf[2] = 16'd4;
      run_instr(16'h0152, 0);
      check("add_op",    32'(e_op), 32'h05);
      check("add_a",     32'(e_a), 32'h4);
      check("add_b",     32'(e_b), 32'h3);
      check("add_cin",   32'(e_cin), 32'h0);
      check("add_we",    32'(w_we), 32'h1);
      check("add_waddr", 32'(w_addr), 32'h1);
      check("add_wdata", 32'(w_data), 32'h7);
      check("add_psr",   32'(psr), 32'h0);
      check("add_pc",    32'(pc), 32'h1);

      // SUB R1,R2
      rf[1] = 16'd5; rf[2] = 16'd5;
      run_instr(16'h0192, 0);
      check("sub_op",    32'(e_op), 32'h05);
      check("sub_a",     32'(e_a), 32'hFFFA);
      check("sub_cin",   32'(e_cin), 32'h1);
      check("sub_wdata", 32'(w_data), 32'h0);
      check("sub_psr",   32'(psr), 32'h01);
      check("sub_pc",    32'(pc), 32'h2);

      // CMP R1,R2 then BLO +4
      rf[1] = 16'd2; rf[2] = 16'd9;
      run_instr(16'h01B2, 0);
      check("cmp_op",  32'(e_op), 32'h0B);
      check("cmp_a",   32'(e_a), 32'h9);
      check("cmp_we",  32'(w_we), 32'h0);
      check("cmp_psr", 32'(psr), 32'h01);
      run_instr(16'hCA04, 0);
      check("blo_aluop", 32'(e_op), 32'h00);
      check("blo_we",    32'(w_we), 32'h0);
      check("blo_pc",    32'(pc), 32'h7);

      // LSH R3,R4
      rf[3] = 16'h0001; rf[4] = 16'hFFFF;
      run_instr(16'h8344, 0);
      check("lsh_op",    32'(e_op), 32'h84);
      check("lsh_a",     32'(e_a), 32'h1);
      check("lsh_b",     32'(e_b), 32'hFFFF);
      check("lsh_waddr", 32'(w_addr), 32'h3);
      check("lsh_wdata", 32'(w_data), 32'h0);

      // MOVI R5,0x80
      run_instr(16'hD580, 0);
      check("movi_we",    32'(w_we), 32'h1);
      check("movi_waddr", 32'(w_addr), 32'h5);
      check("movi_wdata", 32'(w_data), 32'hFF80);
      check("movi_psr",   32'(psr), 32'h01);
      check("movi_pc",    32'(pc), 32'h9);

      // BR -10 to 0xFFFF, then BR +1 wraps to 0
      run_instr(16'hCEF6, 0);
      check("br_back_pc", 32'(pc), 32'hFFFF);
      run_instr(16'hCE01, 0);
      check("br_wrap_pc", 32'(pc), 32'h0000);

      // BEQ with Z clear: not taken
      run_instr(16'hC005, 0);
      check("beq_nt_pc", 32'(pc), 32'h1);

      // ANDI R6,0xF0 (zero-extended)
      rf[6] = 16'h1234;
      run_instr(16'h16F0, 0);
      check("andi_op",    32'(e_op), 32'h01);
      check("andi_a",     32'(e_a), 32'h00F0);
      check("andi_b",     32'(e_b), 32'h1234);
      check("andi_wdata", 32'(w_data), 32'h0030);
      check("andi_pc",    32'(pc), 32'h2);

      // delayed ack, then reset pulse during EXECUTE
      wait_req();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("dly_req_held", 32'(bus.imem_req), 32'h1);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h0152;
      @(posedge clk); #1;
      bus.imem_ack  = 1'b0;
      @(posedge clk); #1;
      check("dly_exec_op", 32'(bus.alu_op), 32'h05);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", 32'(bus.imem_req), 32'h0);
      check("mid_rst_we",  32'(bus.rf_we), 32'h0);
      check("mid_rst_pc",  32'(pc), 32'h0);
      check("mid_rst_psr", 32'(psr), 32'h0);
      check("mid_rst_op",  32'(bus.alu_op), 32'h0);
      @(posedge clk); #1;
      check("mid_rst_we2", 32'(bus.rf_we), 32'h0);
      rst_n = 1'b1;

      // HALT
      wait_req();
      bus.imem_ack  = 1'b1;
      bus.imem_data = 16'h0000;
      @(posedge clk); #1;
      bus.imem_ack  = 1'b0;
      @(posedge clk); #1;
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_req",  32'(bus.imem_req), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("halt_pc",    32'(pc), 32'h0);
      check("halt_flag2", 32'(halted), 32'h1);
      check("halt_we",    32'(bus.rf_we), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
